// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master: FSM state encoding,
// default bus widths and wait-counter helpers.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;
  localparam int WAIT_W     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  // Counter value at which a stalled ACCESS phase gives up.
  function automatic logic [WAIT_W-1:0] timeout_last(input int timeout);
    return WAIT_W'(timeout - 1);
  endfunction

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] value);
    if (value == {WAIT_W{1'b1}}) begin
      return value;
    end else begin
      return value + {{(WAIT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// Request/response handshake plus APB bus signals of the APB master,
// with modports for the master itself and for whatever drives it.
interface apb_master_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master: turns valid/ready requests into APB
// SETUP/ACCESS transfers with back-to-back support and a wait-state timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input logic          PCLK,
  input logic          RESET,
  apb_master_if.master bus
);

  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = timeout_last(TIMEOUT);

  apb_state_e        state_r;
  logic              psel_r;
  logic              penable_r;
  logic              pwrite_r;
  logic [ADDR_W-1:0] paddr_r;
  logic [DATA_W-1:0] pwdata_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              rsp_err_r;
  logic [WAIT_W-1:0] wait_cnt_r;

  logic              complete_s;
  logic              req_ready_s;
  logic              accept_s;

  // Completion of the ACCESS phase and request acceptance for this cycle
  always_comb begin
    complete_s = 1'b0;
    if (state_r == ACCESS) begin
      complete_s = bus.PREADY || (wait_cnt_r == TIMEOUT_LAST);
    end else begin
      complete_s = 1'b0;
    end
    req_ready_s = (state_r == IDLE) || complete_s;
    accept_s    = bus.req_valid && req_ready_s;
  end

  // Transfer FSM with registered APB drive, response and wait counter
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      state_r     <= IDLE;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      pwrite_r    <= 1'b0;
      paddr_r     <= '0;
      pwdata_r    <= '0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
      wait_cnt_r  <= '0;
    end else begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            paddr_r   <= bus.req_addr;
            pwrite_r  <= bus.req_write;
            pwdata_r  <= bus.req_wdata;
            psel_r    <= 1'b1;
            penable_r <= 1'b0;
            state_r   <= SETUP;
          end else begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            state_r   <= IDLE;
          end
        end
        SETUP: begin
          psel_r     <= 1'b1;
          penable_r  <= 1'b1;
          wait_cnt_r <= '0;
          state_r    <= ACCESS;
        end
        ACCESS: begin
          if (complete_s) begin
            // PREADY wins over a coincident timeout; read data only on a real read.
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= ~bus.PREADY;
            rsp_rdata_r <= (bus.PREADY && !pwrite_r) ? bus.PRDATA : '0;
            if (accept_s) begin
              paddr_r   <= bus.req_addr;
              pwrite_r  <= bus.req_write;
              pwdata_r  <= bus.req_wdata;
              psel_r    <= 1'b1;
              penable_r <= 1'b0;
              state_r   <= SETUP;
            end else begin
              psel_r    <= 1'b0;
              penable_r <= 1'b0;
              state_r   <= IDLE;
            end
          end else begin
            wait_cnt_r <= sat_inc(wait_cnt_r);
            state_r    <= ACCESS;
          end
        end
        default: begin
          psel_r    <= 1'b0;
          penable_r <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.PSEL      = psel_r;
  assign bus.PENABLE   = penable_r;
  assign bus.PWRITE    = pwrite_r;
  assign bus.PADDR     = paddr_r;
  assign bus.PWDATA    = pwdata_r;

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL provide parameter ADDR_W, 8, width of request address and PADDR.
REQ-002 SHALL provide parameter DATA_W, 8, width of write/read data.
REQ-003 SHALL provide parameter TIMEOUT, 16, maximum ACCESS cycles with PREADY low before an error completion; legal range 1..255.
REQ-004 SHALL have port PCLK  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted when req_valid and req_ready are both high.
REQ-008 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  ADDR_W  transfer address.
REQ-010 SHALL have port req_wdata  input  DATA_W  write data.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-012 SHALL have port rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-013 SHALL have port rsp_err  output  1  timeout completion flag, valid with rsp_valid.
REQ-014 SHALL have ports PSEL, PENABLE, PWRITE  output  1 each  APB control.
REQ-015 SHALL have ports PADDR  output  ADDR_W, PWDATA  output  DATA_W  APB address and write data.
REQ-016 SHALL have ports PRDATA  input  DATA_W, PREADY  input  1  APB slave read data and ready.

Function
REQ-017 SHALL implement FSM IDLE, SETUP, ACCESS; PSEL=0/PENABLE=0 in IDLE, PSEL=1/PENABLE=0 in SETUP, PSEL=1/PENABLE=1 in ACCESS, all registered outputs.
REQ-018 SHALL drive req_ready = (state==IDLE) or (state==ACCESS and completion this cycle).
REQ-019 SHALL, on acceptance, register req_addr/req_write/req_wdata into PADDR/PWRITE/PWDATA and enter SETUP next cycle.
REQ-020 SHALL move SETUP -> ACCESS unconditionally after exactly one cycle.
REQ-021 SHALL complete in ACCESS when PREADY=1 is sampled, or when the wait counter reaches TIMEOUT-1 with PREADY=0 (timeout).
REQ-022 SHALL, on completion, go to SETUP if a request is accepted in the same cycle (back-to-back, PSEL held high), else IDLE.
REQ-023 SHALL hold PADDR, PWRITE, PWDATA stable from SETUP through the completing ACCESS cycle, and retain last values in IDLE.
REQ-024 SHALL pulse rsp_valid the cycle after completion, with rsp_rdata = PRDATA sampled at completion for reads, 0 for writes; rsp_err=1, rsp_rdata=0 on timeout.
REQ-025 SHALL clear the wait counter on entry to ACCESS; it counts ACCESS cycles with PREADY=0 and saturates, never wraps.
REQ-026 SHALL give latency: accept in cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3 with zero wait states; sustained throughput one transfer per 2 cycles.
REQ-027 SHALL treat PREADY=1 coinciding with the timeout cycle as normal completion (rsp_err=0).

Reset
REQ-028 SHALL, on RESET high, immediately force state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
REQ-029 SHALL abandon an in-flight transfer on reset mid-operation without issuing rsp_valid; req_ready=1 from the first clock after RESET deasserts.

Structure
REQ-030 SHALL place the state enum (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10) and default ADDR_W/DATA_W constants in shared package apb_pkg.
REQ-031 SHALL be a single module; the wait counter stays inline, no sub-module.

Verification
REQ-032 Write addr 0x12 data 0xA5, PREADY=1 -> SETUP N+1, ACCESS N+2, rsp_valid N+3, rsp_err=0, rsp_rdata=0.
REQ-033 Read addr 0x12, PREADY low 3 cycles, PRDATA=0x5A -> ACCESS lasts 4 cycles, PADDR stable, rsp_rdata=0x5A.
REQ-034 Two writes back-to-back (0x01, 0x02) -> PSEL stays high, PENABLE 0,1,0,1, completions 2 cycles apart.
REQ-035 TIMEOUT=4, PREADY held 0 -> completion after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0, return to IDLE.
REQ-036 RESET asserted during ACCESS -> PSEL/PENABLE drop asynchronously, no rsp_valid, next request runs normally.
